vga_stream_out: RTL and testbench
=================================

Name: vga_stream_out

Overview:
- Parametrised VGA output stage; successor to the fixed 4-bit-per-channel vga_port export on the jsv system.
- Generates VGA timing from configurable porch/sync parameters and a configurable pixel-clock divider.
- Takes rendered pixels as a valid/ready stream with a start-of-frame marker and buffers them in a small FIFO.
- Detects underflow and frame misalignment, and re-locks to the stream at the next frame boundary.

Parameters:
- COLOR_W, 4, bits per colour channel.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- SYNC_POL, 0, sync asserted level (0 = active-low).
- PIX_DIV, 2, clk_clk cycles per pixel (>=1).
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, >=4).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  run timing; low forces IDLE.
- pix_valid  in  1  source pixel valid.
- pix_ready  out  1  FIFO can accept (= !full).
- pix_data  in  3*COLOR_W  {R,G,B}.
- pix_sof  in  1  marks pixel (0,0) of a frame.
- vga_red / vga_green / vga_blue  out  COLOR_W each  colour outputs.
- vga_hs, vga_vs  out  1  sync outputs.
- frame_start  out  1  one-cycle pulse at pixel (0,0).
- locked  out  1  high in RUNNING.
- err_count  out  16  saturating underflow/misalign count.

Behaviour:
- Reset values: all outputs 0 except vga_hs/vga_vs = !SYNC_POL; FIFO flushed; counters 0; state IDLE.
- Pixel tick:
  - divider counts 0..PIX_DIV-1; tick when divider = PIX_DIV-1; PIX_DIV=1 ticks every cycle.
  - Divider is held at 0 in IDLE.
- Counters, advanced on tick only:
  - h 0..H_TOTAL-1 (H_TOTAL = sum of H params); wraps to 0 and advances v.
  - v 0..V_TOTAL-1; wraps to 0.
- Region decode:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted likewise on v.
  - Asserted level = SYNC_POL.
- Output timing:
  - All outputs registered; updated only on tick cycles and held between ticks.
  - RGB, hs, vs and frame_start appear 1 clk_clk after the tick they are decoded from, mutually aligned.
  - RGB = 0 whenever not active.
- FIFO:
  - Push on pix_valid && pix_ready; stores {sof, data}.
  - Pop only as stated below.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - pix_ready = !full, so a push is never attempted when full.
- FSM:
  - IDLE: entered on reset or whenever enable=0. Counters held at (0,0); syncs inactive; RGB 0; FIFO not popped. Go to WAIT_SOF when enable=1.
  - WAIT_SOF:
    - Timing runs; RGB 0.
    - If the FIFO head has sof=0, pop it (one per clk_clk, any cycle).
    - If the head has sof=1, hold it.
    - On the tick at (h,v)=(0,0) with head sof=1: go to RUNNING and pop/display that pixel on this tick.
  - RUNNING:
    - On each active tick, pop the head and display it.
    - Error on an active tick if the FIFO is empty, the head has sof=1 at a position other than (0,0), or the head has sof=0 at (0,0).
    - On error: display 0 for that pixel, do not pop, increment err_count (saturates at 0xFFFF), go to WAIT_SOF.
- frame_start pulses on every (0,0) tick in WAIT_SOF or RUNNING, regardless of lock.
- enable falling mid-frame: go to IDLE next cycle; FIFO contents kept; err_count kept.
- reset_reset mid-operation takes priority over all other events.

Decomposition:
- Shared package vga_pkg:
  - state enum {IDLE, WAIT_SOF, RUNNING};
  - a function computing H_TOTAL/V_TOTAL;
  - the pixel struct {sof, r, g, b}.
- One sub-module, sync_fifo: parametrised width/depth, single clock, synchronous active-high reset, show-ahead head, full/empty flags.
- Timing counters and FSM stay in vga_stream_out.

Test Plan:
Bench params: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), COLOR_W 4, PIX_DIV 1, FIFO_DEPTH 16, SYNC_POL 0.
- Reset then enable=1, no pixels -> vga_hs low for h=5..6, vga_vs low on v=4, period 48 clk; RGB 0; locked=0; frame_start every 48 clk; err_count 0.
- Stream 12 pixels with sof on the first, data = index 0..11 -> locked rises at the next (0,0); outputs 0x000..0x00B in raster order, 1 clk after each tick; err_count 0.
- Starve the source after 7 of 12 pixels -> at pixel 7 RGB=0, err_count=1, locked=0; a full frame resent with sof relocks at the next (0,0).
- Feed 3 pixels without sof, then a full frame -> the 3 pixels are discarded in WAIT_SOF, lock occurs, displayed frame correct.
- Fill the FIFO to 16 with enable=0 -> pix_ready=0 at 16 entries; raise enable -> lock at first (0,0), ready reasserts after the first pop.
- PIX_DIV=2: timing period 96 clk; each RGB value held 2 clk; reset_reset asserted mid-frame -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA stream output stage.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSof,
    StRunning
  } state_e;

  // Widest colour channel the pixel record can carry.
  localparam int unsigned ColorWMax = 8;

  typedef struct packed {
    logic                 sof;
    logic [ColorWMax-1:0] r;
    logic [ColorWMax-1:0] g;
    logic [ColorWMax-1:0] b;
  } pixel_t;

  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head and full/empty flags.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/vga_stream_out.sv
// VGA timing generator fed by a buffered pixel stream; locks to the stream on
// start-of-frame and falls back to searching for it on underflow or misalignment.
module vga_stream_out
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_POL   = 0,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 enable,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_sof,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start,
  output logic                 locked,
  output logic [15:0]          err_count
);

  localparam int unsigned HTotal   = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal   = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW       = $clog2(HTotal);
  localparam int unsigned VW       = $clog2(VTotal);
  localparam int unsigned DivW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned PixW     = 3 * COLOR_W;
  localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd = HSyncBeg + H_SYNC;
  localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd = VSyncBeg + V_SYNC;

  localparam logic            SyncAct = (SYNC_POL != 0);
  localparam logic            SyncIdl = !SyncAct;
  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);
  localparam logic [HW-1:0]   HOne    = HW'(1);
  localparam logic [VW-1:0]   VOne    = VW'(1);

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [PixW-1:0]   rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              fs_q, fs_d;
  logic [15:0]       err_q, err_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [PixW:0]     fifo_rdata;
  pixel_t            head;
  logic              unused_head;

  logic run, tick, origin, active, hs_on, vs_on, show, err_hit;

  sync_fifo #(
    .Width (PixW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .push_i  (pix_valid && pix_ready),
    .wdata_i ({pix_sof, pix_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    head                = '0;
    head.sof            = fifo_rdata[PixW];
    head.r[COLOR_W-1:0] = fifo_rdata[3*COLOR_W-1 -: COLOR_W];
    head.g[COLOR_W-1:0] = fifo_rdata[2*COLOR_W-1 -: COLOR_W];
    head.b[COLOR_W-1:0] = fifo_rdata[COLOR_W-1 -: COLOR_W];
  end
  assign unused_head = ^head;

  assign run    = enable && (state_q != StIdle);
  assign tick   = run && (div_q == DivLast);
  assign origin = (h_q == '0) && (v_q == '0);
  assign active = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign hs_on  = (32'(h_q) >= HSyncBeg) && (32'(h_q) < HSyncEnd);
  assign vs_on  = (32'(v_q) >= VSyncBeg) && (32'(v_q) < VSyncEnd);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    err_hit  = 1'b0;
    show     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitSof;
      end
      StWaitSof: begin
        // Discard stale pixels until a frame start sits at the head.
        if (!fifo_empty && !head.sof) begin
          fifo_pop = 1'b1;
        end else if (tick && origin && !fifo_empty) begin
          state_d  = StRunning;
          fifo_pop = 1'b1;
          show     = 1'b1;
        end
      end
      StRunning: begin
        if (tick && active) begin
          if (fifo_empty || (head.sof != origin)) begin
            err_hit = 1'b1;
            state_d = StWaitSof;
          end else begin
            fifo_pop = 1'b1;
            show     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d  = StIdle;
      fifo_pop = 1'b0;
      err_hit  = 1'b0;
      show     = 1'b0;
    end
  end

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!run) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = tick ? '0 : div_q + DivOne;
      if (tick) begin
        if (32'(h_q) == HTotal - 1) begin
          h_d = '0;
          v_d = (32'(v_q) == VTotal - 1) ? '0 : v_q + VOne;
        end else begin
          h_d = h_q + HOne;
        end
      end
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    err_d = err_q;
    if (!run) begin
      rgb_d = '0;
      hs_d  = SyncIdl;
      vs_d  = SyncIdl;
    end else if (tick) begin
      rgb_d = show ? {head.r[COLOR_W-1:0], head.g[COLOR_W-1:0], head.b[COLOR_W-1:0]} : '0;
      hs_d  = hs_on ? SyncAct : SyncIdl;
      vs_d  = vs_on ? SyncAct : SyncIdl;
      fs_d  = origin;
    end
    if (err_hit && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      rgb_q   <= '0;
      hs_q    <= SyncIdl;
      vs_q    <= SyncIdl;
      fs_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      err_q   <= err_d;
    end
  end

  assign pix_ready   = !fifo_full;
  assign vga_red     = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_green   = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_blue    = rgb_q[COLOR_W-1 -: COLOR_W];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == StRunning);
  assign err_count   = err_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a tiny 8x6 raster, PIX_DIV 1 and 2.
module tb_vga_stream_out;

  typedef struct {
    int          n;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
    logic        lk;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, en1, valid1, sof1, ready1, hs1, vs1, fs1, lk1;
  logic [11:0] data1;
  logic [3:0]  r1, g1, b1;
  logic [15:0] err1;
  logic        rst2, en2, valid2, sof2, ready2, hs2, vs2, fs2, lk2;
  logic [11:0] data2;
  logic [3:0]  r2, g2, b2;
  logic [15:0] err2;

  int tests  = 0;
  int failed = 0;
  int n      = 0;

  vga_stream_out #(
    .COLOR_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .PIX_DIV(1), .FIFO_DEPTH(16)
  ) dut1 (
    .clk_clk(clk), .reset_reset(rst1), .enable(en1), .pix_valid(valid1),
    .pix_ready(ready1), .pix_data(data1), .pix_sof(sof1),
    .vga_red(r1), .vga_green(g1), .vga_blue(b1), .vga_hs(hs1), .vga_vs(vs1),
    .frame_start(fs1), .locked(lk1), .err_count(err1)
  );

  vga_stream_out #(
    .COLOR_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .PIX_DIV(2), .FIFO_DEPTH(16)
  ) dut2 (
    .clk_clk(clk), .reset_reset(rst2), .enable(en2), .pix_valid(valid2),
    .pix_ready(ready2), .pix_data(data2), .pix_sof(sof2),
    .vga_red(r2), .vga_green(g2), .vga_blue(b2), .vga_hs(hs2), .vga_vs(vs2),
    .frame_start(fs2), .locked(lk2), .err_count(err2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_n(input int target);
    while (n < target) step();
    check("cycle alignment", n, target);
  endtask

  task automatic reset1();
    rst1 = 1'b1; en1 = 1'b0; valid1 = 1'b0; sof1 = 1'b0; data1 = '0;
    step(); step();
    rst1 = 1'b0;
  endtask

  task automatic reset2();
    rst2 = 1'b1; en2 = 1'b0; valid2 = 1'b0; sof2 = 1'b0; data2 = '0;
    step(); step();
    rst2 = 1'b0;
  endtask

  task automatic push1(input logic sof, input logic [11:0] data);
    valid1 = 1'b1; sof1 = sof; data1 = data;
    step();
    valid1 = 1'b0; sof1 = 1'b0;
  endtask

  task automatic push2(input logic sof, input logic [11:0] data);
    valid2 = 1'b1; sof2 = sof; data2 = data;
    step();
    valid2 = 1'b0; sof2 = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input logic hs, input logic vs,
                           input logic fs, input logic [11:0] rgb, input logic lk);
    check($sformatf("%s hs n=%0d", tag, v.n), hs, v.hs);
    check($sformatf("%s vs n=%0d", tag, v.n), vs, v.vs);
    check($sformatf("%s frame_start n=%0d", tag, v.n), fs, v.fs);
    check($sformatf("%s rgb n=%0d", tag, v.n), rgb, v.rgb);
    check($sformatf("%s locked n=%0d", tag, v.n), lk, v.lk);
  endtask

  vec_t t1[13];
  vec_t t6[15];

  initial begin
    // Free-running timing, no pixels: {n, hs, vs, fs, rgb, locked}
    t1[0]  = '{1,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[1]  = '{2,  1'b1, 1'b1, 1'b1, 12'h000, 1'b0};
    t1[2]  = '{3,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[3]  = '{7,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[4]  = '{8,  1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[5]  = '{9,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[6]  = '{10, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[7]  = '{34, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
    t1[8]  = '{39, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0};
    t1[9]  = '{42, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[10] = '{49, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t1[11] = '{50, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0};
    t1[12] = '{98, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0};
    // PIX_DIV=2 with a 12-pixel frame of 0x0E0+i queued before enable
    t6[0]  = '{1,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t6[1]  = '{2,  1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    t6[2]  = '{3,  1'b1, 1'b1, 1'b1, 12'h0E0, 1'b1};
    t6[3]  = '{4,  1'b1, 1'b1, 1'b0, 12'h0E0, 1'b1};
    t6[4]  = '{5,  1'b1, 1'b1, 1'b0, 12'h0E1, 1'b1};
    t6[5]  = '{6,  1'b1, 1'b1, 1'b0, 12'h0E1, 1'b1};
    t6[6]  = '{12, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[7]  = '{13, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[8]  = '{16, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[9]  = '{17, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[10] = '{19, 1'b1, 1'b1, 1'b0, 12'h0E4, 1'b1};
    t6[11] = '{66, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[12] = '{67, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1};
    t6[13] = '{98, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    t6[14] = '{99, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0};

    reset2();
    reset1();

    // Reset values
    check("reset hs", hs1, 1'b1);
    check("reset vs", vs1, 1'b1);
    check("reset rgb", {r1, g1, b1}, 12'h000);
    check("reset frame_start", fs1, 1'b0);
    check("reset locked", lk1, 1'b0);
    check("reset err_count", err1, 16'd0);
    check("reset pix_ready", ready1, 1'b1);

    // Timing with an empty source
    n = 0; en1 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      wait_n(t1[i].n);
      check_vec("idle-src", t1[i], hs1, vs1, fs1, {r1, g1, b1}, lk1);
    end
    check("idle-src err_count", err1, 16'd0);

    // One full frame in raster order, then underflow at the next frame start
    reset1();
    for (int i = 0; i < 12; i++) push1(i == 0, 12'(i));
    n = 0; en1 = 1'b1;
    for (int p = 0; p < 48; p++) begin
      int h, v;
      logic [11:0] exp;
      h = p % 8; v = p / 8;
      exp = (h < 4 && v < 3) ? 12'(v * 4 + h) : 12'h000;
      wait_n(p + 2);
      check($sformatf("frame rgb p=%0d", p), {r1, g1, b1}, exp);
      check($sformatf("frame locked p=%0d", p), lk1, 1'b1);
    end
    check("frame err_count", err1, 16'd0);
    wait_n(50);
    check("underflow rgb", {r1, g1, b1}, 12'h000);
    check("underflow locked", lk1, 1'b0);
    check("underflow err_count", err1, 16'd1);
    check("underflow frame_start", fs1, 1'b1);

    // Starve after 7 pixels, then resend a frame
    reset1();
    for (int i = 0; i < 7; i++) push1(i == 0, 12'(i));
    n = 0; en1 = 1'b1;
    wait_n(12);
    check("starve rgb pix6", {r1, g1, b1}, 12'h006);
    check("starve locked pix6", lk1, 1'b1);
    wait_n(13);
    check("starve rgb pix7", {r1, g1, b1}, 12'h000);
    check("starve locked pix7", lk1, 1'b0);
    check("starve err_count", err1, 16'd1);
    for (int i = 0; i < 12; i++) push1(i == 0, 12'h0A0 + 12'(i));
    wait_n(49);
    check("relock before origin", lk1, 1'b0);
    wait_n(50);
    check("relock locked", lk1, 1'b1);
    check("relock rgb pix0", {r1, g1, b1}, 12'h0A0);
    check("relock err_count", err1, 16'd1);
    wait_n(51);
    check("relock rgb pix1", {r1, g1, b1}, 12'h0A1);
    wait_n(60);
    check("relock rgb pix6", {r1, g1, b1}, 12'h0A6);

    // Three stray pixels ahead of the frame are discarded
    reset1();
    for (int i = 0; i < 3; i++) push1(1'b0, 12'hF00 + 12'(i));
    for (int i = 0; i < 12; i++) push1(i == 0, 12'h0C0 + 12'(i));
    n = 0; en1 = 1'b1;
    wait_n(2);
    check("stray locked n=2", lk1, 1'b0);
    check("stray rgb n=2", {r1, g1, b1}, 12'h000);
    wait_n(49);
    check("stray locked n=49", lk1, 1'b0);
    wait_n(50);
    check("stray locked n=50", lk1, 1'b1);
    check("stray rgb pix0", {r1, g1, b1}, 12'h0C0);
    wait_n(51);
    check("stray rgb pix1", {r1, g1, b1}, 12'h0C1);
    wait_n(59);
    check("stray rgb pix5", {r1, g1, b1}, 12'h0C5);
    wait_n(68);
    check("stray rgb pix10", {r1, g1, b1}, 12'h0CA);
    check("stray err_count", err1, 16'd0);

    // Fill the FIFO while disabled
    reset1();
    for (int i = 0; i < 16; i++) begin
      push1(i == 0 || i == 12, 12'h050 + 12'(i));
      if (i == 14) check("fill ready at 15", ready1, 1'b1);
    end
    check("fill ready at 16", ready1, 1'b0);
    n = 0; en1 = 1'b1;
    step();
    check("fill ready n=1", ready1, 1'b0);
    check("fill locked n=1", lk1, 1'b0);
    step();
    check("fill ready after pop", ready1, 1'b1);
    check("fill locked n=2", lk1, 1'b1);
    check("fill rgb pix0", {r1, g1, b1}, 12'h050);
    step();
    check("fill rgb pix1", {r1, g1, b1}, 12'h051);

    // PIX_DIV=2 timing, pixel hold and mid-frame reset
    en1 = 1'b0;
    for (int i = 0; i < 12; i++) push2(i == 0, 12'h0E0 + 12'(i));
    n = 0; en2 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      wait_n(t6[i].n);
      check_vec("div2", t6[i], hs2, vs2, fs2, {r2, g2, b2}, lk2);
    end
    check("div2 err_count n=99", err2, 16'd1);
    for (int i = 0; i < 12; i++) push2(i == 0, 12'h0E0 + 12'(i));
    wait_n(195);
    check("div2 relock", lk2, 1'b1);
    check("div2 relock rgb", {r2, g2, b2}, 12'h0E0);
    wait_n(197);
    check("div2 pre-reset rgb", {r2, g2, b2}, 12'h0E1);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    check("div2 reset rgb", {r2, g2, b2}, 12'h000);
    check("div2 reset hs", hs2, 1'b1);
    check("div2 reset vs", vs2, 1'b1);
    check("div2 reset frame_start", fs2, 1'b0);
    check("div2 reset locked", lk2, 1'b0);
    check("div2 reset err_count", err2, 16'd0);
    check("div2 reset pix_ready", ready2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests,
             failed);
    $fatal(1, "watchdog expired");
  end

endmodule
